// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit APB timer: TCR field positions, clock-select codes,
// register addresses and the counter operation encoding used by the counting engine.
package timer_pkg;

   localparam int TMR_WIDTH = 8;
   localparam int TMR_DIV_W = 4;

   localparam int TCR_LOAD   = 7;
   localparam int TCR_UPDN   = 5;
   localparam int TCR_EN     = 4;
   localparam int TCR_CKS_HI = 1;
   localparam int TCR_CKS_LO = 0;

   typedef enum logic [1:0] {
      CKS_DIV2  = 2'd0,
      CKS_DIV4  = 2'd1,
      CKS_DIV8  = 2'd2,
      CKS_DIV16 = 2'd3
   } cks_e;

   localparam logic [1:0] ADDR_TDR = 2'h0;
   localparam logic [1:0] ADDR_TCR = 2'h1;
   localparam logic [1:0] ADDR_TSR = 2'h2;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_LOAD = 2'd1,
      CNT_UP   = 2'd2,
      CNT_DOWN = 2'd3
   } cnt_op_e;

   typedef struct packed {
      logic ovf;
      logic udf;
   } wrap_t;

   // Number of pclk cycles between ticks for a given clock-select code.
   function automatic int cks_period(input logic [1:0] cks);
      return 2 << cks;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running pclk divider; tick is a registered one-cycle pulse on the rising edge of
// div_cnt[cks], i.e. once every 2^(cks+1) pclk. No backpressure; runs regardless of en/load.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int DIV_W = TMR_DIV_W
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic [1:0] cks,
   output logic       tick
);

   logic [DIV_W-1:0] r_div_cnt;
   logic             r_sel_q;
   logic             r_tick;
   logic             w_sel;

   assign w_sel = r_div_cnt[cks];

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_div_cnt <= '0;
         r_sel_q   <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
         r_sel_q   <= w_sel;
         r_tick    <= w_sel & ~r_sel_q;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/timer_counter_core.sv
// Timer counting engine: load/up/down counter with registered wrap pulses, 1 pclk load latency.
// Optional sticky interrupt built when TMR_IRQ_EN is defined (set beats clear).
module timer_counter_core
   import timer_pkg::*;
#(
   parameter int WIDTH = TMR_WIDTH,
   parameter int DIV_W = TMR_DIV_W
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic [WIDTH-1:0] tdr,
   input  logic             load,
   input  logic             up_dn,
   input  logic             en,
   input  logic [1:0]       cks,
   output logic [WIDTH-1:0] tcnt,
   output logic             ovf_pls,
   output logic             udf_pls
`ifdef TMR_IRQ_EN
   ,
   output logic             tmr_irq,
   input  logic             irq_clr
`endif
);

   logic             w_tick;
   cnt_op_e          w_op;
   logic [WIDTH-1:0] r_tcnt;
   logic [WIDTH-1:0] w_tcnt_nxt;
   wrap_t            r_wrap;
   wrap_t            w_wrap_nxt;
   logic             w_at_max;
   logic             w_at_zero;

   timer_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .pclk   (pclk),
      .preset (preset),
      .cks    (cks),
      .tick   (w_tick)
   );

   // load dominates; the tick is only consumed when enabled and not loading
   always_comb begin
      w_op = CNT_HOLD;
      if (load) begin
         w_op = CNT_LOAD;
      end else if (en && w_tick) begin
         w_op = up_dn ? CNT_DOWN : CNT_UP;
      end
   end

   assign w_at_max  = &r_tcnt;
   assign w_at_zero = ~|r_tcnt;

   always_comb begin
      w_tcnt_nxt     = r_tcnt;
      w_wrap_nxt.ovf = 1'b0;
      w_wrap_nxt.udf = 1'b0;
      case (w_op)
         CNT_LOAD: w_tcnt_nxt = tdr;
         CNT_UP: begin
            w_tcnt_nxt     = r_tcnt + WIDTH'(1);
            w_wrap_nxt.ovf = w_at_max;
         end
         CNT_DOWN: begin
            w_tcnt_nxt     = r_tcnt - WIDTH'(1);
            w_wrap_nxt.udf = w_at_zero;
         end
         default: w_tcnt_nxt = r_tcnt;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_tcnt <= '0;
         r_wrap <= '0;
      end else begin
         r_tcnt <= w_tcnt_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign tcnt    = r_tcnt;
   assign ovf_pls = r_wrap.ovf;
   assign udf_pls = r_wrap.udf;

`ifdef TMR_IRQ_EN
   logic r_irq;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_irq <= 1'b0;
      end else if (r_wrap.ovf || r_wrap.udf) begin
         r_irq <= 1'b1;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign tmr_irq = r_irq;
`endif

endmodule
